// File: rtl/raster_bus_sched.sv
`default_nettype none
// ============================================================================
// Module   : raster_bus_sched
// Purpose  : Per-cycle VIC-II memory bus scheduler. Decides the owner of the
//            phi-low and phi-high halves of each CPU cycle (refresh, char,
//            graphics, sprite pointer/data, idle, CPU). Also produces the
//            badline condition, BA, AEC and the sprite index.
// Revision : 1.0 - initial release
// ============================================================================
module raster_bus_sched #(
  parameter logic [8:0] BADLINE_FIRST = 9'h030,
  parameter logic [8:0] BADLINE_LAST  = 9'h0F7
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       cycle_start,
  input  logic       clk_phi,
  input  logic [1:0] chip,
  input  logic [6:0] cycle_num,
  input  logic [8:0] raster_line,
  input  logic [2:0] yscroll,
  input  logic       den,
  input  logic [7:0] sprite_dma,
  output logic [2:0] type_lo,
  output logic [2:0] type_hi,
  output logic [2:0] sprite_idx,
  output logic       badline,
  output logic       ba,
  output logic       aec
);

  // Chip select codes
  localparam logic [1:0] CHIP6567R56A = 2'd0;
  localparam logic [1:0] CHIP6567R8   = 2'd1;
  localparam logic [1:0] CHIP6569     = 2'd2;
  localparam logic [1:0] CHIPUNUSED   = 2'd3;

  // Access type codes
  localparam logic [2:0] T_IDLE    = 3'd0;
  localparam logic [2:0] T_REFRESH = 3'd1;
  localparam logic [2:0] T_CHAR    = 3'd2;
  localparam logic [2:0] T_GFX     = 3'd3;
  localparam logic [2:0] T_SPTR    = 3'd4;
  localparam logic [2:0] T_SDATA   = 3'd5;
  localparam logic [2:0] T_CPU     = 3'd6;

  // Single conditional subtraction; callers guarantee v < 2n.
  function automatic logic [7:0] mod_n(input logic [7:0] v, input logic [7:0] n);
    return (v >= n) ? (v - n) : v;
  endfunction

  logic       den_latch_q, den_latch_d;
  logic [7:0] dma_prev_q,  dma_prev_d;
  logic [2:0] type_lo_q,   type_lo_d;
  logic [2:0] type_hi_q,   type_hi_d;
  logic [2:0] sprite_idx_q, sprite_idx_d;
  logic       badline_q,   badline_d;
  logic       ba_q,        ba_d;

  logic [7:0] n_cyc;
  logic [7:0] spr0;
  logic [7:0] cyc8;
  logic       in_range;
  logic       bl_eval;
  logic [2:0] dec_lo;
  logic [2:0] dec_hi;
  logic [2:0] dec_idx;
  logic       ba_req;
  logic [7:0] p_cyc;
  logic [7:0] p1_cyc;
  logic [7:0] win_ofs;

  // Line length and sprite 0 pointer cycle for the selected chip
  always_comb begin
    n_cyc = 8'd63;
    spr0  = 8'd57;
    case (chip)
      CHIP6567R8: begin
        n_cyc = 8'd65;
        spr0  = 8'd58;
      end
      CHIP6567R56A: begin
        n_cyc = 8'd64;
        spr0  = 8'd57;
      end
      CHIP6569, CHIPUNUSED: begin
        n_cyc = 8'd63;
        spr0  = 8'd57;
      end
    endcase
  end

  // DEN latch update and badline evaluation for the cycle being started
  always_comb begin
    den_latch_d = den_latch_q;
    if (cycle_start) begin
      if (raster_line == 9'd0) begin
        den_latch_d = 1'b0;
      end else if ((raster_line == BADLINE_FIRST) && den) begin
        den_latch_d = 1'b1;
      end
    end
    bl_eval = den_latch_d &&
              (raster_line >= BADLINE_FIRST) &&
              (raster_line <= BADLINE_LAST) &&
              (raster_line[2:0] == yscroll);
  end

  // Per-cycle access decode: background fetches first, sprite slots override
  always_comb begin
    cyc8     = {1'b0, cycle_num};
    in_range = (cyc8 < n_cyc);
    dec_lo   = T_IDLE;
    dec_hi   = T_CPU;
    dec_idx  = 3'd0;
    ba_req   = 1'b0;
    p_cyc    = 8'd0;
    p1_cyc   = 8'd0;
    win_ofs  = 8'd0;
    if (in_range) begin
      if ((cyc8 >= 8'd10) && (cyc8 <= 8'd14)) dec_lo = T_REFRESH;
      if ((cyc8 >= 8'd15) && (cyc8 <= 8'd54)) dec_lo = T_GFX;
      if (bl_eval && (cyc8 >= 8'd14) && (cyc8 <= 8'd53)) dec_hi = T_CHAR;
      if (bl_eval && (cyc8 >= 8'd11) && (cyc8 <= 8'd53)) ba_req = 1'b1;
      for (int s = 0; s < 8; s++) begin
        p_cyc  = mod_n(spr0 + 8'(2 * s), n_cyc);
        p1_cyc = mod_n(p_cyc + 8'd1, n_cyc);
        // Distance from P(s)-3 going forward around the line
        win_ofs = mod_n(mod_n(cyc8 + n_cyc + 8'd3 - p_cyc, n_cyc), n_cyc);
        if (cyc8 == p_cyc) begin
          dec_lo  = T_SPTR;
          dec_idx = 3'(s);
          if (sprite_dma[s]) dec_hi = T_SDATA;
        end
        if (cyc8 == p1_cyc) begin
          dec_idx = 3'(s);
          // DMA decision was taken when the pointer cycle started
          if (dma_prev_q[s]) begin
            dec_lo = T_SDATA;
            dec_hi = T_SDATA;
          end else begin
            dec_lo = T_IDLE;
            dec_hi = T_CPU;
          end
        end
        if (sprite_dma[s] && (win_ofs <= 8'd4)) ba_req = 1'b1;
      end
    end
  end

  // Load the decoded values at cycle_start, hold them otherwise
  always_comb begin
    dma_prev_d   = dma_prev_q;
    type_lo_d    = type_lo_q;
    type_hi_d    = type_hi_q;
    sprite_idx_d = sprite_idx_q;
    badline_d    = badline_q;
    ba_d         = ba_q;
    if (cycle_start) begin
      dma_prev_d   = sprite_dma;
      type_lo_d    = dec_lo;
      type_hi_d    = dec_hi;
      sprite_idx_d = dec_idx;
      badline_d    = bl_eval;
      ba_d         = ~ba_req;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      den_latch_q  <= 1'b0;
      dma_prev_q   <= 8'd0;
      type_lo_q    <= T_IDLE;
      type_hi_q    <= T_CPU;
      sprite_idx_q <= 3'd0;
      badline_q    <= 1'b0;
      ba_q         <= 1'b1;
    end else begin
      den_latch_q  <= den_latch_d;
      dma_prev_q   <= dma_prev_d;
      type_lo_q    <= type_lo_d;
      type_hi_q    <= type_hi_d;
      sprite_idx_q <= sprite_idx_d;
      badline_q    <= badline_d;
      ba_q         <= ba_d;
    end
  end

  assign type_lo    = type_lo_q;
  assign type_hi    = type_hi_q;
  assign sprite_idx = sprite_idx_q;
  assign badline    = badline_q;
  assign ba         = ba_q;
  // VIC owns the bus in phi-low, and in phi-high only for c and s accesses
  assign aec        = clk_phi & ~((type_hi_q == T_CHAR) || (type_hi_q == T_SDATA));

endmodule
`default_nettype wire

// File: tb/tb_raster_bus_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_bus_sched
// Purpose  : Directed self-checking bench for raster_bus_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_bus_sched;

  logic       clk_dot4x = 1'b0;
  logic       rst;
  logic       cycle_start;
  logic       clk_phi;
  logic [1:0] chip;
  logic [6:0] cycle_num;
  logic [8:0] raster_line;
  logic [2:0] yscroll;
  logic       den;
  logic [7:0] sprite_dma;
  logic [2:0] type_lo;
  logic [2:0] type_hi;
  logic [2:0] sprite_idx;
  logic       badline;
  logic       ba;
  logic       aec;

  localparam logic [1:0] C_R8   = 2'd1;
  localparam logic [1:0] C_6569 = 2'd2;

  int checks = 0;
  int errors = 0;

  logic [2:0] o_lo, o_hi, o_idx;
  logic       o_bl, o_ba, o_aec_lo, o_aec_hi;

  raster_bus_sched dut (
    .clk_dot4x  (clk_dot4x),
    .rst        (rst),
    .cycle_start(cycle_start),
    .clk_phi    (clk_phi),
    .chip       (chip),
    .cycle_num  (cycle_num),
    .raster_line(raster_line),
    .yscroll    (yscroll),
    .den        (den),
    .sprite_dma (sprite_dma),
    .type_lo    (type_lo),
    .type_hi    (type_hi),
    .sprite_idx (sprite_idx),
    .badline    (badline),
    .ba         (ba),
    .aec        (aec)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  // 6569 pointer cycles for sprites 0..7: 57,59,61,0,2,4,6,8
  function automatic bit is_p6569(int c);
    return (c == 57) || (c == 59) || (c == 61) || (c == 0) ||
           (c == 2) || (c == 4) || (c == 6) || (c == 8);
  endfunction

  // Background type_lo for a 6569 line without sprite DMA
  function automatic logic [2:0] base_lo6569(int c);
    if (c >= 10 && c <= 14) return 3'd1;
    if (c >= 15 && c <= 54) return 3'd3;
    if (is_p6569(c)) return 3'd4;
    return 3'd0;
  endfunction

  // One CPU cycle of four clk_dot4x periods; captures outputs in both phases
  task automatic cpu_cycle(input logic [6:0] cyc);
    @(negedge clk_dot4x);
    cycle_num   = cyc;
    cycle_start = 1'b1;
    clk_phi     = 1'b0;
    @(negedge clk_dot4x);
    cycle_start = 1'b0;
    o_lo = type_lo; o_hi = type_hi; o_idx = sprite_idx;
    o_bl = badline; o_ba = ba; o_aec_lo = aec;
    @(negedge clk_dot4x);
    clk_phi = 1'b1;
    #1 o_aec_hi = aec;
    @(negedge clk_dot4x);
  endtask

  task automatic test_reset;
    rst = 1'b1; cycle_start = 1'b0; clk_phi = 1'b1;
    repeat (3) @(negedge clk_dot4x);
    checks++; if (type_lo !== 3'd0) begin errors++; $display("FAIL reset_type_lo actual=%0d required=0", type_lo); end
    checks++; if (type_hi !== 3'd6) begin errors++; $display("FAIL reset_type_hi actual=%0d required=6", type_hi); end
    checks++; if (sprite_idx !== 3'd0) begin errors++; $display("FAIL reset_sprite_idx actual=%0d required=0", sprite_idx); end
    checks++; if (badline !== 1'b0) begin errors++; $display("FAIL reset_badline actual=%0b required=0", badline); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL reset_ba actual=%0b required=1", ba); end
    checks++; if (aec !== 1'b1) begin errors++; $display("FAIL reset_aec actual=%0b required=1", aec); end
    // cycle_start coinciding with reset must not load a decode
    cycle_num = 7'd20; cycle_start = 1'b1;
    @(negedge clk_dot4x);
    cycle_start = 1'b0;
    checks++; if (type_lo !== 3'd0) begin errors++; $display("FAIL reset_wins_lo actual=%0d required=0", type_lo); end
    rst = 1'b0;
  endtask

  task automatic test_badline;
    logic [2:0] elo, ehi;
    logic       eba, eaec;
    chip = C_6569; den = 1'b1; yscroll = 3'd3; sprite_dma = 8'h00;
    raster_line = 9'h030;
    cpu_cycle(7'd0);
    raster_line = 9'h033;
    for (int c = 0; c < 63; c++) begin
      cpu_cycle(7'(c));
      elo  = base_lo6569(c);
      ehi  = (c >= 14 && c <= 53) ? 3'd2 : 3'd6;
      eba  = (c >= 11 && c <= 53) ? 1'b0 : 1'b1;
      eaec = (c >= 14 && c <= 53) ? 1'b0 : 1'b1;
      checks++; if (o_bl !== 1'b1) begin errors++; $display("FAIL bl_badline cyc=%0d actual=%0b required=1", c, o_bl); end
      checks++; if (o_lo !== elo) begin errors++; $display("FAIL bl_type_lo cyc=%0d actual=%0d required=%0d", c, o_lo, elo); end
      checks++; if (o_hi !== ehi) begin errors++; $display("FAIL bl_type_hi cyc=%0d actual=%0d required=%0d", c, o_hi, ehi); end
      checks++; if (o_ba !== eba) begin errors++; $display("FAIL bl_ba cyc=%0d actual=%0b required=%0b", c, o_ba, eba); end
      checks++; if (o_aec_hi !== eaec) begin errors++; $display("FAIL bl_aec_hi cyc=%0d actual=%0b required=%0b", c, o_aec_hi, eaec); end
      checks++; if (o_aec_lo !== 1'b0) begin errors++; $display("FAIL bl_aec_lo cyc=%0d actual=%0b required=0", c, o_aec_lo); end
    end
  endtask

  task automatic test_no_badline;
    logic [2:0] elo;
    raster_line = 9'h034;
    for (int c = 0; c < 63; c++) begin
      cpu_cycle(7'(c));
      elo = base_lo6569(c);
      checks++; if (o_bl !== 1'b0) begin errors++; $display("FAIL nobl_badline cyc=%0d actual=%0b required=0", c, o_bl); end
      checks++; if (o_lo !== elo) begin errors++; $display("FAIL nobl_type_lo cyc=%0d actual=%0d required=%0d", c, o_lo, elo); end
      checks++; if (o_hi !== 3'd6) begin errors++; $display("FAIL nobl_type_hi cyc=%0d actual=%0d required=6", c, o_hi); end
      checks++; if (o_ba !== 1'b1) begin errors++; $display("FAIL nobl_ba cyc=%0d actual=%0b required=1", c, o_ba); end
    end
  endtask

  task automatic test_sprite0;
    logic [2:0] elo, ehi;
    logic       eba;
    raster_line = 9'h040; sprite_dma = 8'h01;
    for (int c = 0; c < 63; c++) begin
      cpu_cycle(7'(c));
      elo = (c == 58) ? 3'd5 : base_lo6569(c);
      ehi = (c == 57 || c == 58) ? 3'd5 : 3'd6;
      eba = (c >= 54 && c <= 58) ? 1'b0 : 1'b1;
      checks++; if (o_lo !== elo) begin errors++; $display("FAIL spr0_type_lo cyc=%0d actual=%0d required=%0d", c, o_lo, elo); end
      checks++; if (o_hi !== ehi) begin errors++; $display("FAIL spr0_type_hi cyc=%0d actual=%0d required=%0d", c, o_hi, ehi); end
      checks++; if (o_ba !== eba) begin errors++; $display("FAIL spr0_ba cyc=%0d actual=%0b required=%0b", c, o_ba, eba); end
      if (c == 57 || c == 58) begin
        checks++; if (o_idx !== 3'd0) begin errors++; $display("FAIL spr0_idx cyc=%0d actual=%0d required=0", c, o_idx); end
        checks++; if (o_aec_hi !== 1'b0) begin errors++; $display("FAIL spr0_aec_hi cyc=%0d actual=%0b required=0", c, o_aec_hi); end
      end
    end
  endtask

  task automatic test_sprite3_wrap;
    logic [2:0] elo, ehi;
    logic       eba;
    int         c;
    sprite_dma = 8'h08;
    for (int k = 0; k < 65; k++) begin
      c = k % 63;
      cpu_cycle(7'(c));
      elo = (c == 1) ? 3'd5 : base_lo6569(c);
      ehi = (c == 0 || c == 1) ? 3'd5 : 3'd6;
      eba = (c >= 60 || c <= 1) ? 1'b0 : 1'b1;
      checks++; if (o_ba !== eba) begin errors++; $display("FAIL spr3_ba step=%0d cyc=%0d actual=%0b required=%0b", k, c, o_ba, eba); end
      checks++; if (o_lo !== elo) begin errors++; $display("FAIL spr3_type_lo step=%0d cyc=%0d actual=%0d required=%0d", k, c, o_lo, elo); end
      checks++; if (o_hi !== ehi) begin errors++; $display("FAIL spr3_type_hi step=%0d cyc=%0d actual=%0d required=%0d", k, c, o_hi, ehi); end
      if (c == 0 || c == 1) begin
        checks++; if (o_idx !== 3'd3) begin errors++; $display("FAIL spr3_idx step=%0d cyc=%0d actual=%0d required=3", k, c, o_idx); end
      end
    end
  endtask

  task automatic test_r8_all;
    logic [2:0] elo, ehi, eidx;
    logic       eba;
    int         c, p, p1;
    chip = C_R8; sprite_dma = 8'hFF; raster_line = 9'h040;
    for (int k = 0; k < 130; k++) begin
      c = k % 65;
      cpu_cycle(7'(c));
      if (k >= 65) begin
        elo = 3'd0; ehi = 3'd6; eidx = 3'd0;
        if (c >= 10 && c <= 14) elo = 3'd1;
        if (c >= 15 && c <= 54) elo = 3'd3;
        // Pointer cycles 58,60,62,64,1,3,5,7
        for (int s = 0; s < 8; s++) begin
          p  = (58 + 2 * s) % 65;
          p1 = (p + 1) % 65;
          if (c == p)  begin elo = 3'd4; ehi = 3'd5; eidx = 3'(s); end
          if (c == p1) begin elo = 3'd5; ehi = 3'd5; eidx = 3'(s); end
        end
        eba = (c >= 55 || c <= 8) ? 1'b0 : 1'b1;
        checks++; if (o_lo !== elo) begin errors++; $display("FAIL r8_type_lo cyc=%0d actual=%0d required=%0d", c, o_lo, elo); end
        checks++; if (o_hi !== ehi) begin errors++; $display("FAIL r8_type_hi cyc=%0d actual=%0d required=%0d", c, o_hi, ehi); end
        checks++; if (o_ba !== eba) begin errors++; $display("FAIL r8_ba cyc=%0d actual=%0b required=%0b", c, o_ba, eba); end
        if (elo == 3'd4 || elo == 3'd5) begin
          checks++; if (o_idx !== eidx) begin errors++; $display("FAIL r8_idx cyc=%0d actual=%0d required=%0d", c, o_idx, eidx); end
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    chip = C_6569; sprite_dma = 8'hFF; raster_line = 9'h040;
    cpu_cycle(7'd63);
    checks++; if (o_lo !== 3'd0) begin errors++; $display("FAIL oor_type_lo actual=%0d required=0", o_lo); end
    checks++; if (o_hi !== 3'd6) begin errors++; $display("FAIL oor_type_hi actual=%0d required=6", o_hi); end
    checks++; if (o_ba !== 1'b1) begin errors++; $display("FAIL oor_ba actual=%0b required=1", o_ba); end
    cpu_cycle(7'd100);
    checks++; if (o_ba !== 1'b1) begin errors++; $display("FAIL oor100_ba actual=%0b required=1", o_ba); end
  endtask

  task automatic test_den_off;
    sprite_dma = 8'h00; chip = C_6569; den = 1'b0; yscroll = 3'd3;
    raster_line = 9'h000;
    cpu_cycle(7'd0);
    raster_line = 9'h030;
    for (int c = 0; c < 63; c++) cpu_cycle(7'(c));
    den = 1'b1;
    raster_line = 9'h033;
    for (int c = 0; c < 63; c++) begin
      cpu_cycle(7'(c));
      checks++; if (o_bl !== 1'b0) begin errors++; $display("FAIL denoff_badline cyc=%0d actual=%0b required=0", c, o_bl); end
      checks++; if (o_hi !== 3'd6) begin errors++; $display("FAIL denoff_type_hi cyc=%0d actual=%0d required=6", c, o_hi); end
      checks++; if (o_ba !== 1'b1) begin errors++; $display("FAIL denoff_ba cyc=%0d actual=%0b required=1", c, o_ba); end
    end
  endtask

  task automatic test_reset_mid;
    den = 1'b1; yscroll = 3'd3; raster_line = 9'h030;
    cpu_cycle(7'd0);
    raster_line = 9'h033;
    for (int c = 0; c < 30; c++) cpu_cycle(7'(c));
    checks++; if (o_bl !== 1'b1) begin errors++; $display("FAIL mid_pre_badline actual=%0b required=1", o_bl); end
    checks++; if (o_hi !== 3'd2) begin errors++; $display("FAIL mid_pre_type_hi actual=%0d required=2", o_hi); end
    // Reset pulse coinciding with cycle 30's cycle_start
    @(negedge clk_dot4x);
    cycle_num = 7'd30; cycle_start = 1'b1; clk_phi = 1'b0; rst = 1'b1;
    @(negedge clk_dot4x);
    cycle_start = 1'b0; rst = 1'b0;
    checks++; if (type_lo !== 3'd0) begin errors++; $display("FAIL mid_type_lo actual=%0d required=0", type_lo); end
    checks++; if (type_hi !== 3'd6) begin errors++; $display("FAIL mid_type_hi actual=%0d required=6", type_hi); end
    checks++; if (sprite_idx !== 3'd0) begin errors++; $display("FAIL mid_sprite_idx actual=%0d required=0", sprite_idx); end
    checks++; if (badline !== 1'b0) begin errors++; $display("FAIL mid_badline actual=%0b required=0", badline); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL mid_ba actual=%0b required=1", ba); end
    @(negedge clk_dot4x);
    clk_phi = 1'b1;
    #1;
    checks++; if (aec !== 1'b1) begin errors++; $display("FAIL mid_aec actual=%0b required=1", aec); end
    checks++; if (type_hi !== 3'd6) begin errors++; $display("FAIL mid_hold_type_hi actual=%0d required=6", type_hi); end
    @(negedge clk_dot4x);
    // DEN latch was cleared by reset, so no badline after restart
    cpu_cycle(7'd31);
    checks++; if (o_bl !== 1'b0) begin errors++; $display("FAIL mid_post_badline actual=%0b required=0", o_bl); end
    checks++; if (o_hi !== 3'd6) begin errors++; $display("FAIL mid_post_type_hi actual=%0d required=6", o_hi); end
    checks++; if (o_lo !== 3'd3) begin errors++; $display("FAIL mid_post_type_lo actual=%0d required=3", o_lo); end
  endtask

  initial begin
    rst = 1'b1; cycle_start = 1'b0; clk_phi = 1'b0; chip = C_6569;
    cycle_num = 7'd0; raster_line = 9'd0; yscroll = 3'd0; den = 1'b0;
    sprite_dma = 8'h00;
    test_reset;
    test_badline;
    test_no_badline;
    test_sprite0;
    test_sprite3_wrap;
    test_r8_all;
    test_out_of_range;
    test_den_off;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
